// File: rtl/std_tpram_wbuf.sv
// std_tpram_wbuf
//   Pseudo two-port RAM (1R + 1W, one clock) on a single-port array.
//   Reads always own the array. A write that collides with a read, or that
//   arrives while older writes are still pending, is parked in an in-order
//   circular write buffer. The buffer drains one entry per read-free cycle.
//
//   Optional feature macro: TPRAM_WBUF_FWD_EN
//     defined   : reads are compared against every valid buffer entry and
//                 the newest matching entry's data is returned.
//     undefined : no comparators are built. rdata always comes from the
//                 array, so a pending buffered write reads back stale.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_rceb      read enable, active-low
//   i_raddr     read address
//   o_rdata     registered read data (1-cycle latency, holds when idle)
//   i_wceb      write enable, active-low
//   i_waddr     write address
//   i_wdata     write data
//   o_wrdy      write accepted this cycle when high (combinational)
//   o_wbuf_cnt  number of buffered writes pending
//   o_busy      o_wbuf_cnt != 0
module std_tpram_wbuf #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rceb,
  input  logic [AW-1:0]                 i_raddr,
  output logic [DW-1:0]                 o_rdata,
  input  logic                          i_wceb,
  input  logic [AW-1:0]                 i_waddr,
  input  logic [DW-1:0]                 i_wdata,
  output logic                          o_wrdy,
  output logic [$clog2(WBUF_DEPTH):0]   o_wbuf_cnt,
  output logic                          o_busy
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_mem [2**AW];

  logic [AW-1:0] r_bad  [WBUF_DEPTH];
  logic [DW-1:0] r_bdat [WBUF_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rdata;

  logic          w_rd, w_nempty, w_full, w_wacc;
  logic          w_push, w_pop, w_direct;
  logic          w_fwd_hit;
  logic [DW-1:0] w_fwd_dat;

  assign w_rd     = ~i_rceb;
  assign w_nempty = (r_cnt != '0);
  assign w_full   = (r_cnt == CW'(WBUF_DEPTH));
  // A full buffer still accepts on a read-free cycle: the head pops that cycle.
  assign o_wrdy   = ~w_full | i_rceb;
  assign w_wacc   = ~i_wceb & o_wrdy;

  // Anything pending forces new writes through the buffer to keep order.
  assign w_pop    = ~w_rd & w_nempty;
  assign w_push   = w_wacc & (w_rd | w_nempty);
  assign w_direct = w_wacc & ~w_rd & ~w_nempty;

`ifdef TPRAM_WBUF_FWD_EN
  // Scan oldest to newest; later hits override so the newest match wins.
  always_comb begin
    w_fwd_hit = 1'b0;
    w_fwd_dat = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((CW'(k) < r_cnt) && (r_bad[r_head + PW'(k)] == i_raddr)) begin
        w_fwd_hit = 1'b1;
        w_fwd_dat = r_bdat[r_head + PW'(k)];
      end
    end
  end
`else
  assign w_fwd_hit = 1'b0;
  assign w_fwd_dat = '0;
`endif

  // Array: read-before-write falls out of the non-blocking update.
  // Writes are suppressed during reset, including a drain on the reset edge.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (w_pop)         r_mem[r_bad[r_head]] <= r_bdat[r_head];
      else if (w_direct) r_mem[i_waddr]       <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_rd) r_rdata <= w_fwd_hit ? w_fwd_dat : r_mem[i_raddr];
      if (w_push) begin
        r_bad[r_tail]  <= i_waddr;
        r_bdat[r_tail] <= i_wdata;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rdata    = r_rdata;
  assign o_wbuf_cnt = r_cnt;
  assign o_busy     = w_nempty;
endmodule
